// File: rtl/md_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_sequencer_pkg
// Description : Shared definitions for the HI/LO multiply/divide sequencer:
//               MDop bit indices, sequencer state encoding, op decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package md_sequencer_pkg;

    // Bit positions inside the decoder's one-hot MDop vector (mirrors mycpu.h)
    localparam int MD_DIV   = 7;
    localparam int MD_DIVU  = 6;
    localparam int MD_MULT  = 5;
    localparam int MD_MULTU = 4;
    localparam int MD_MFHI  = 3;
    localparam int MD_MFLO  = 2;
    localparam int MD_MTHI  = 1;
    localparam int MD_MTLO  = 0;

    localparam int MD_OP_W  = 8;

    // Sequencer states (MD_IDLE / MD_MUL / MD_DIV in the C header)
    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_MUL  = 2'd1,
        MD_ST_DIV  = 2'd2
    } md_state_e;

    // An MDop vector is real work only when exactly one bit is set
    function automatic logic md_op_is_legal(input logic [MD_OP_W-1:0] op);
        return (op != '0) && ((op & (op - 1'b1)) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : md_div_iter
// Description : Iterative radix-2 restoring divider on 32-bit unsigned
//               magnitudes. One quotient bit per cycle after start; done is
//               high for the single cycle after the last step. Sign handling
//               and special cases are left to the caller.
// Revision    : 1.0 - initial release
// ============================================================================
module md_div_iter #(
    parameter int DIV_ITER = 32     // must equal the operand width for a full quotient
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    localparam int CNT_W = $clog2(DIV_ITER + 1);

    logic             running_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rem_q;
    logic [31:0]      quo_q;
    logic [31:0]      dvs_q;

    // Partial remainder shifted left by one, pulling in the next dividend bit
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] diff;

    assign shifted = {rem_q, quo_q[31]};
    assign fits    = (shifted >= {1'b0, dvs_q});
    // When fits is set the true difference is below the divisor, so 32 bits hold it
    assign diff    = shifted[31:0] - dvs_q;

    // Load on start, then one restoring step per cycle until the counter drains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
        end else if (abort_i) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
        end else if (start_i) begin
            running_q <= 1'b1;
            cnt_q     <= CNT_W'(DIV_ITER);
            rem_q     <= '0;
            quo_q     <= dividend_i;
            dvs_q     <= divisor_i;
        end else if (running_q) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
                if (fits) begin
                    rem_q <= diff;
                    quo_q <= {quo_q[30:0], 1'b1};
                end else begin
                    rem_q <= shifted[31:0];
                    quo_q <= {quo_q[30:0], 1'b0};
                end
            end else begin
                // Result has been offered for one cycle; release it
                running_q <= 1'b0;
            end
        end
    end

    assign done_o = running_q && (cnt_q == '0);
    assign quot_o = quo_q;
    assign rem_o  = rem_q;

endmodule
`default_nettype wire

// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : md_sequencer
// Description : HI/LO multiply/divide sequencer. Accepts one MDop per
//               handshake, runs MULT/MULTU through a fixed-latency multiply
//               and DIV/DIVU through md_div_iter, owns HI/LO, and holds off
//               the EX stage while a result is pending.
// Revision    : 1.0 - initial release
// ============================================================================
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int MUL_LAT  = 2,     // accept edge to HI/LO write for mult, 1..4
    parameter int DIV_ITER = 32     // divider steps; divide latency is DIV_ITER+1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        rs_value,
    input  logic [31:0]        rt_value,
    input  logic               cancel,
    output logic               op_ready,
    output logic [31:0]        rd_data,
    output logic               busy,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);

    md_state_e   state_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // Multiply operands and countdown
    logic [31:0] mul_a_q;
    logic [31:0] mul_b_q;
    logic        mul_signed_q;
    logic [2:0]  mul_cnt_q;

    // Divide sign and override bookkeeping captured at accept
    logic        q_neg_q;
    logic        r_neg_q;
    logic        div_zero_q;
    logic        div_ovf_q;
    logic [31:0] div_rs_q;

    logic        accept;
    logic        is_mul_op;
    logic        is_div_op;
    logic        div_signed;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [63:0] mul_a_ext;
    logic [63:0] mul_b_ext;
    logic [63:0] product;
    logic        div_done;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic [31:0] quot_d;
    logic [31:0] rem_d;

    // Cancel masks the handshake so a flushed instruction never starts work
    assign op_ready   = (state_q == MD_ST_IDLE) && !cancel;
    assign accept     = op_valid && op_ready && md_op_is_legal(md_op);
    assign is_mul_op  = md_op[MD_MULT] | md_op[MD_MULTU];
    assign is_div_op  = md_op[MD_DIV]  | md_op[MD_DIVU];
    assign div_signed = md_op[MD_DIV];

    assign rs_mag = (div_signed && rs_value[31]) ? (~rs_value + 32'd1) : rs_value;
    assign rt_mag = (div_signed && rt_value[31]) ? (~rt_value + 32'd1) : rt_value;

    // Extending to 64 bits first makes the low 64 product bits correct for both signednesses
    assign mul_a_ext = mul_signed_q ? {{32{mul_a_q[31]}}, mul_a_q} : {32'd0, mul_a_q};
    assign mul_b_ext = mul_signed_q ? {{32{mul_b_q[31]}}, mul_b_q} : {32'd0, mul_b_q};
    assign product   = mul_a_ext * mul_b_ext;

    md_div_iter #(
        .DIV_ITER (DIV_ITER)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .start_i    (accept && is_div_op),
        .abort_i    (cancel),
        .dividend_i (rs_mag),
        .divisor_i  (rt_mag),
        .done_o     (div_done),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    // Sign fix-up of the magnitude result, then divide-by-zero / overflow overrides
    always_comb begin
        quot_d = q_neg_q ? (~div_quot + 32'd1) : div_quot;
        rem_d  = r_neg_q ? (~div_rem  + 32'd1) : div_rem;
        if (div_zero_q) begin
            quot_d = 32'hFFFF_FFFF;
            rem_d  = div_rs_q;
        end else if (div_ovf_q) begin
            quot_d = 32'h8000_0000;
            rem_d  = 32'd0;
        end
    end

    // Sequencer FSM: accepts ops in IDLE, owns HI/LO, cancel beats any completing write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= MD_ST_IDLE;
            hi_q         <= '0;
            lo_q         <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_signed_q <= 1'b0;
            mul_cnt_q    <= '0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            div_zero_q   <= 1'b0;
            div_ovf_q    <= 1'b0;
            div_rs_q     <= '0;
        end else begin
            case (state_q)
                MD_ST_IDLE: begin
                    if (accept) begin
                        if (is_mul_op) begin
                            mul_a_q      <= rs_value;
                            mul_b_q      <= rt_value;
                            mul_signed_q <= md_op[MD_MULT];
                            mul_cnt_q    <= 3'(MUL_LAT - 1);
                            state_q      <= MD_ST_MUL;
                        end else if (is_div_op) begin
                            q_neg_q    <= div_signed && (rs_value[31] ^ rt_value[31]);
                            r_neg_q    <= div_signed && rs_value[31];
                            div_zero_q <= (rt_value == 32'd0);
                            div_ovf_q  <= div_signed && (rs_value == 32'h8000_0000)
                                          && (rt_value == 32'hFFFF_FFFF);
                            div_rs_q   <= rs_value;
                            state_q    <= MD_ST_DIV;
                        end else if (md_op[MD_MTHI]) begin
                            hi_q <= rs_value;
                        end else if (md_op[MD_MTLO]) begin
                            lo_q <= rs_value;
                        end
                    end
                end
                MD_ST_MUL: begin
                    if (cancel) begin
                        state_q <= MD_ST_IDLE;
                    end else if (mul_cnt_q == 3'd0) begin
                        hi_q    <= product[63:32];
                        lo_q    <= product[31:0];
                        state_q <= MD_ST_IDLE;
                    end else begin
                        mul_cnt_q <= mul_cnt_q - 3'd1;
                    end
                end
                MD_ST_DIV: begin
                    if (cancel) begin
                        state_q <= MD_ST_IDLE;
                    end else if (div_done) begin
                        hi_q    <= rem_d;
                        lo_q    <= quot_d;
                        state_q <= MD_ST_IDLE;
                    end
                end
                default: state_q <= MD_ST_IDLE;
            endcase
        end
    end

    assign busy    = (state_q != MD_ST_IDLE);
    assign rd_data = md_op[MD_MFHI] ? hi_q : lo_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_sequencer
// Description : Self-checking bench for md_sequencer: directed vector table,
//               multi-cycle corner sequences and randomized ops checked
//               against an arithmetic reference model of HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_sequencer;

    localparam int MUL_LAT  = 2;
    localparam int DIV_ITER = 32;
    localparam int DIV_LAT  = DIV_ITER + 1;
    localparam int TIMEOUT  = 200;

    localparam logic [7:0] OP_DIV   = 8'h80;
    localparam logic [7:0] OP_DIVU  = 8'h40;
    localparam logic [7:0] OP_MULT  = 8'h20;
    localparam logic [7:0] OP_MULTU = 8'h10;
    localparam logic [7:0] OP_MFHI  = 8'h08;
    localparam logic [7:0] OP_MFLO  = 8'h04;
    localparam logic [7:0] OP_MTHI  = 8'h02;
    localparam logic [7:0] OP_MTLO  = 8'h01;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        op_valid = 1'b0;
    logic [7:0]  md_op    = 8'd0;
    logic [31:0] rs_value = 32'd0;
    logic [31:0] rt_value = 32'd0;
    logic        cancel   = 1'b0;
    logic        op_ready;
    logic [31:0] rd_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t tbl [8];

    md_sequencer #(
        .MUL_LAT  (MUL_LAT),
        .DIV_ITER (DIV_ITER)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .md_op    (md_op),
        .rs_value (rs_value),
        .rt_value (rt_value),
        .cancel   (cancel),
        .op_ready (op_ready),
        .rd_data  (rd_data),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Architectural result {hi,lo} of one op, computed with plain integer arithmetic
    function automatic logic [63:0] ref_result(input logic [7:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] h,
                                               input logic [31:0] l);
        longint p;
        int     q;
        int     r;
        case (op)
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            OP_MTHI: return {a, l};
            OP_MTLO: return {h, a};
            default: return {h, l};
        endcase
    endfunction

    function automatic int exp_lat(input logic [7:0] op);
        if (op == OP_MULT || op == OP_MULTU) return MUL_LAT;
        if (op == OP_DIV || op == OP_DIVU) return DIV_LAT;
        return 0;
    endfunction

    // Present one op starting at a falling edge, wait for its result, check against the model
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        logic [63:0] r;
        int          lat;
        int          n;
        op_valid = 1'b1;
        md_op    = op;
        rs_value = a;
        rt_value = b;
        #1;
        chk({tag, " op_ready"}, 64'(op_ready), 64'd1);
        if (op == OP_MFHI) chk({tag, " mfhi rd_data"}, 64'(rd_data), 64'(m_hi));
        if (op == OP_MFLO) chk({tag, " mflo rd_data"}, 64'(rd_data), 64'(m_lo));
        r   = ref_result(op, a, b, m_hi, m_lo);
        lat = exp_lat(op);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        md_op    = 8'd0;
        n        = 0;
        if (lat > 0) begin
            chk({tag, " busy after accept"}, 64'(busy), 64'd1);
            while (busy && n < TIMEOUT) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk({tag, " latency"}, 64'(n), 64'(lat));
        end
        m_hi = r[63:32];
        m_lo = r[31:0];
        chk({tag, " hi"}, 64'(hi), 64'(m_hi));
        chk({tag, " lo"}, 64'(lo), 64'(m_lo));
        @(negedge clk);
    endtask

    // Start a divide without waiting for it; returns just after the accept edge
    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        md_op    = OP_DIV;
        rs_value = a;
        rt_value = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        md_op    = 8'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          k;

        tbl[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
        tbl[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA};
        tbl[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3] = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14};
        tbl[4] = '{OP_DIVU,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF};
        tbl[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
        tbl[6] = '{OP_DIV,   32'd100,       32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFF2};
        tbl[7] = '{OP_DIV,   32'd0,         32'd0,        32'd0,         32'hFFFF_FFFF};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset op_ready", 64'(op_ready), 64'd1);
        chk("reset busy",     64'(busy),     64'd0);
        chk("reset hi",       64'(hi),       64'd0);
        chk("reset lo",       64'(lo),       64'd0);
        chk("reset rd_data",  64'(rd_data),  64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].op, tbl[i].rs, tbl[i].rt, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d const hi", i), 64'(hi), 64'(tbl[i].exp_hi));
            chk($sformatf("tbl%0d const lo", i), 64'(lo), 64'(tbl[i].exp_lo));
        end

        // MTHI then MFHI in the very next cycle
        issue(OP_MTHI, 32'hA5A5_A5A5, 32'd0, "mthi");
        issue(OP_MFHI, 32'd0, 32'd0, "mfhi next");
        chk("mfhi const", 64'(m_hi), 64'h0000_0000_A5A5_A5A5);

        // MFLO presented one cycle after a DIV accept is held off until completion
        r = ref_result(OP_DIV, 32'hFFFF_FFF9, 32'd2, m_hi, m_lo);
        start_div(32'hFFFF_FFF9, 32'd2);
        op_valid = 1'b1;
        md_op    = OP_MFLO;
        k        = 0;
        while (!op_ready && k < TIMEOUT) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("mflo stall cycles", 64'(k), 64'(DIV_LAT));
        m_hi = r[63:32];
        m_lo = r[31:0];
        chk("mflo rd_data", 64'(rd_data), 64'h0000_0000_FFFF_FFFD);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        md_op    = 8'd0;
        chk("mflo no busy", 64'(busy), 64'd0);
        chk("mflo hi", 64'(hi), 64'(m_hi));
        @(negedge clk);

        // Cancel at iteration 10 leaves HI/LO untouched, and late divider completion is ignored
        issue(OP_MTHI, 32'h1111_2222, 32'd0, "pre hi");
        issue(OP_MTLO, 32'h3333_4444, 32'd0, "pre lo");
        start_div(32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("cancel10 busy", 64'(busy), 64'd0);
        chk("cancel10 hi", 64'(hi), 64'(m_hi));
        chk("cancel10 lo", 64'(lo), 64'(m_lo));
        repeat (DIV_LAT) @(posedge clk);
        #1;
        chk("cancel10 late hi", 64'(hi), 64'(m_hi));
        chk("cancel10 late lo", 64'(lo), 64'(m_lo));
        @(negedge clk);

        // Cancel on the completion edge suppresses the write
        start_div(32'd100, 32'd7);
        repeat (DIV_ITER) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("cancel done busy", 64'(busy), 64'd0);
        chk("cancel done hi", 64'(hi), 64'(m_hi));
        chk("cancel done lo", 64'(lo), 64'(m_lo));
        @(negedge clk);
        issue(OP_DIVU, 32'd100, 32'd7, "after cancel");

        // Cancel in IDLE masks the handshake
        cancel   = 1'b1;
        op_valid = 1'b1;
        md_op    = OP_MTHI;
        rs_value = 32'hDEAD_BEEF;
        #1;
        chk("cancel idle op_ready", 64'(op_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("cancel idle hi", 64'(hi), 64'(m_hi));
        cancel   = 1'b0;
        op_valid = 1'b0;
        md_op    = 8'd0;
        @(negedge clk);

        // Illegal multi-bit md_op is not work
        op_valid = 1'b1;
        md_op    = OP_MULT | OP_MTHI;
        rs_value = 32'hCAFE_F00D;
        rt_value = 32'd5;
        #1;
        chk("illegal op_ready", 64'(op_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("illegal busy", 64'(busy), 64'd0);
        chk("illegal hi", 64'(hi), 64'(m_hi));
        chk("illegal lo", 64'(lo), 64'(m_lo));
        // op_valid low is ignored whatever md_op says
        op_valid = 1'b0;
        md_op    = OP_MTLO;
        @(posedge clk);
        #1;
        chk("novalid lo", 64'(lo), 64'(m_lo));
        md_op = OP_DIV;
        @(posedge clk);
        #1;
        chk("novalid busy", 64'(busy), 64'd0);
        md_op = 8'd0;
        @(negedge clk);

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            op = 8'h01 << $urandom_range(0, 7);
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = 32'($urandom);
            endcase
            issue(op, a, b, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of a divide
        issue(OP_MTHI, 32'h0BAD_0001, 32'd0, "pre rst hi");
        issue(OP_MTLO, 32'h0BAD_0002, 32'd0, "pre rst lo");
        start_div(32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst mid busy", 64'(busy), 64'd0);
        chk("rst mid hi", 64'(hi), 64'd0);
        chk("rst mid lo", 64'(lo), 64'd0);
        chk("rst mid op_ready", 64'(op_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        @(negedge clk);
        issue(OP_MULT, 32'd7, 32'hFFFF_FFFD, "post rst mult");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
Sequencer for the HI/LO multiply/divide resource driven by the decoder's 8-bit MDop vector.
- Accepts one MD operation per handshake from the EX stage.
- Runs MULT/MULTU through a fixed-latency multiply pipe and DIV/DIVU through an iterative radix-2 divider.
- Owns the HI/LO registers.
- Back-pressures EX (op_ready low) while a result is pending, so MFHI/MFLO/MTHI/MTLO and new MD ops never race an in-flight op.

Parameters:
MUL_LAT, 2, cycles from accept edge to HI/LO update for MULT/MULTU (range 1..4)
DIV_ITER, 32, divider iterations; total div latency = DIV_ITER+1 cycles

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
op_valid  in  1  EX stage presents an MD op
md_op  in  8  one-hot {div,divu,mult,multu,mfhi,mflo,mthi,mtlo}; all-zero = no op
rs_value  in  32  operand A / MTHI-MTLO source
rt_value  in  32  operand B
cancel  in  1  exception flush: abort in-flight op
op_ready  out  1  op accepted this cycle when op_valid&op_ready
rd_data  out  32  HI (mfhi) or LO (mflo), combinational from HI/LO
busy  out  1  mult/div in flight
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset, asynchronous: state=IDLE; hi=lo=0; busy=0; iteration counter=0.
  - op_ready=1 at reset, since it is combinational from IDLE.
  - rd_data=0 at reset, since hi=lo=0.
- States and transitions:
  - IDLE → MUL on accepted mult/multu.
  - IDLE → DIV on accepted div/divu.
  - MUL → IDLE after MUL_LAT cycles.
  - DIV → IDLE after DIV_ITER+1 cycles.
  - Any state → IDLE on cancel.
- op_ready = (state==IDLE). Any op_valid with nonzero md_op is refused while busy, including mfhi/mflo/mthi/mtlo.
- busy = (state!=IDLE).
- Accept edge T, mult/multu:
  - Operands latched at T.
  - {hi,lo} = 64-bit product (signed for mult, unsigned for multu), written at edge T+MUL_LAT.
  - op_ready is 1 again in the cycle after that edge.
- Accept edge T, div/divu:
  - At T: operand magnitudes and signs latched.
  - Edges T+1..T+DIV_ITER: one restoring step each.
  - Edge T+DIV_ITER+1: sign fix-up, then lo=quotient, hi=remainder.
  - Signed rules: quotient negative iff the operand signs differ; remainder takes the dividend's sign.
- Divide boundary cases:
  - Divide-by-zero (rt==0), both div and divu: lo=32'hFFFFFFFF, hi=rs_value; still takes the full latency.
  - Signed 0x80000000 / -1: lo=0x80000000, hi=0.
- mthi/mtlo when accepted: hi (resp. lo) = rs_value at the accept edge; single-cycle, state stays IDLE.
- mfhi/mflo:
  - rd_data = mfhi ? hi : lo, combinational.
  - Valid in the accept cycle; no state change.
  - mfhi in the cycle after an mthi edge returns the new value.
- cancel:
  - Forces IDLE at the next edge with hi/lo unchanged; it dominates a completing write on the same edge.
  - A concurrent op_valid is not accepted in a cycle where cancel=1 (op_ready is masked by cancel).
- Illegal md_op (more than one bit set): treated as no op and not accepted as work; op_ready still reflects state.
- Ops with op_valid=0 are ignored regardless of md_op.

Decomposition:
- Shared header alongside mycpu.h:
  - MDop bit-index defines: MD_DIV=7, MD_DIVU=6, MD_MULT=5, MD_MULTU=4, MD_MFHI=3, MD_MFLO=2, MD_MTHI=1, MD_MTLO=0.
  - State encodings MD_IDLE/MD_MUL/MD_DIV.
- One sub-module: md_div_iter.
  - Iterative restoring divider with start/done, 32-bit unsigned magnitudes in, quotient/remainder out.
  - The sequencer does the sign handling and the zero/overflow overrides.

Test Plan:
- MULT rs=0xFFFFFFFE, rt=3, MUL_LAT=2 → busy for 2 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA at T+2. MULTU with the same operands → hi=0x2, lo=0xFFFFFFFA.
- DIV rs=-7 (0xFFFFFFF9), rt=2 → op_ready low for 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2.
- DIVU rt=0, rs=0x1234 → lo=0xFFFFFFFF, hi=0x1234 after 33 cycles. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MFLO issued one cycle after DIV accept → op_ready=0 until completion, then rd_data equals the new lo in the acceptance cycle.
- DIV accepted, cancel at iteration 10 → IDLE next edge, hi/lo keep pre-op values. Cancel on the completion edge → no write.
- MTHI rs=0xA5A5A5A5, then MFHI the next cycle → rd_data=0xA5A5A5A5. Assert reset mid-DIV → hi=lo=0, busy=0 immediately.
